fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage pipelined processor, directly upstream of decode.
//  Holds the PC and a word-addressed instruction ROM, which the bench loads via $readmemh into array `block`.
//  Every cycle it fetches the instruction at PC and registers it into the IF/ID pipeline latch consumed by decode.
//  Accepts stall from hazard detection and branch/jump redirect (with flush) from execute.
// PARAMETERS
//  IMEM_DEPTH   256  instruction ROM depth in 32-bit words (power of 2)
//  RESET_PC     0    PC value loaded on reset (word aligned)
// PORTS
//  clk          in   1   clock, rising-edge active
//  reset        in   1   asynchronous, active-high reset
//  stall        in   1   hold PC and IF/ID latch this cycle
//  redirect_en  in   1   branch/jump taken; load redirect_pc, flush IF/ID
//  redirect_pc  in   32  target address for redirect
//  pc_out       out  32  current PC (the address being fetched this cycle)
//  ifid_instr   out  32  registered instruction for decode
//  ifid_pc4     out  32  registered PC+4 of that instruction
//  ifid_valid   out  1   IF/ID latch holds a real instruction (0 = bubble)
//  fetch_count  out  32  number of instructions latched valid into IF/ID, saturating
// BEHAVIOUR
//  Reset (async, immediate): pc_out=RESET_PC, ifid_instr=0, ifid_pc4=0, ifid_valid=0, fetch_count=0.
//   ROM `block` is never reset or written by RTL.
//  ROM read is combinational: word index = pc_out[log2(IMEM_DEPTH)+1:2], modulo IMEM_DEPTH.
//   Out-of-range PCs alias to the low words.
//  Each rising edge, priority reset > redirect_en > stall > normal:
//   redirect_en=1: pc_out<=redirect_pc with bits[1:0] forced to 0; ifid_valid<=0; ifid_instr<=0 (NOP);
//    ifid_pc4<=0; fetch_count unchanged. Redirect wins over a simultaneous stall.
//   stall=1 (no redirect): pc_out, ifid_*, and fetch_count all hold.
//   normal: pc_out<=pc_out+4 (32-bit wrap, 0xFFFFFFFC->0); ifid_instr<=ROM[pc]; ifid_pc4<=pc_out+4;
//    ifid_valid<=1; fetch_count<=fetch_count+1, saturating at 0xFFFFFFFF.
//  Latency: an instruction fetched at PC in cycle n is visible on ifid_* after edge n (1 cycle).
//  The first valid IF/ID appears after the first edge following reset release.
//  Timing after reset release with no stall or redirect: pc_out = 4*k after the k-th rising edge.
//  Reset asserted mid-operation discards any in-flight redirect or stall; no state survives.
//  Inputs are sampled only at the clock edge; stall and redirect have no combinational path to outputs.
// TESTING
//  T1 free-run: release reset, 10ns clock, ROM[i]=i -> pc_out=0,4,8,... ifid_instr=0,1,2,... ifid_valid=1 from edge 1;
//     pc_out=0x4C after 19 edges.
//  T2 stall: assert stall for 3 edges at pc=0x10 -> pc_out stays 0x10, ifid_instr stays ROM[3], fetch_count frozen;
//     resumes at 0x14.
//  T3 redirect: redirect_en=1, redirect_pc=0x43 at pc=0x20 -> next pc_out=0x40, ifid_valid=0, ifid_instr=0;
//     following edge ifid_instr=ROM[16], valid=1.
//  T4 redirect+stall same cycle: stall=1, redirect_en=1, redirect_pc=0x8 -> pc_out=0x8 and bubble; stall ignored.
//  T5 wrap: redirect_pc=0xFFFFFFFC, then one normal edge -> pc_out=0x0, ifid_pc4=0x0,
//     ifid_instr=ROM[IMEM_DEPTH-1].
//  T6 mid-run reset: assert reset between edges at pc=0x30 -> outputs zero immediately (before next edge);
//     after release, sequence restarts at 0.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : PC register, combinational instruction ROM and IF/ID pipeline latch
// Revision : 1.0
// ============================================================================
module fetch_stage #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc_out,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [31:0] fetch_count
);

    localparam int c_ADDR_W = $clog2(IMEM_DEPTH);

    // Instruction ROM, loaded externally; the design never writes it.
    logic [31:0] block [0:IMEM_DEPTH-1];

    logic [31:0] pc_q,    pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q,   pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;

    logic [c_ADDR_W-1:0] w_rom_idx;
    logic [31:0]         w_rom_word;
    logic [31:0]         w_pc_plus4;

    // Upper PC bits are ignored so out-of-range addresses alias to low words.
    assign w_rom_idx  = pc_q[c_ADDR_W+1:2];
    assign w_rom_word = block[w_rom_idx];
    assign w_pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        count_d = count_q;
        if (redirect_en) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            instr_d = 32'd0;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
        end else if (!stall) begin
            pc_d    = w_pc_plus4;
            instr_d = w_rom_word;
            pc4_d   = w_pc_plus4;
            valid_d = 1'b1;
            if (count_q != 32'hFFFF_FFFF) begin
                count_d = count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign pc_out      = pc_q;
    assign ifid_instr  = instr_q;
    assign ifid_pc4    = pc4_q;
    assign ifid_valid  = valid_q;
    assign fetch_count = count_q;

endmodule
`default_nettype wire
